// File: rtl/ex_muldiv.sv
// Iterative RISC-V M-extension execute unit: radix-2 shift-add multiply, restoring divide.
// Latency XLEN+1 cycles (1 on divide fast paths); busy_o stalls the pipeline, flush_i aborts.
module ex_muldiv #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start_i,
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] op1_i,
    input  logic [XLEN-1:0] op2_i,
    input  logic [4:0]      rd_addr_i,
    input  logic            flush_i,
    output logic            busy_o,
    output logic [4:0]      rd_addr_o,
    output logic [XLEN-1:0] rd_data_o,
    output logic            rd_wen_o
);

    localparam int CW = $clog2(XLEN);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0]   opb_q, opb_d;
    logic [2:0]        funct3_q, funct3_d;
    logic              neg_q, neg_d;
    logic [4:0]        rd_q, rd_d;
    logic [4:0]        rd_addr_q, rd_addr_d;
    logic [XLEN-1:0]   rd_data_q, rd_data_d;
    logic              rd_wen_q, rd_wen_d;

    logic              is_div, s1, s2, neg1, neg2, div0, ovf;
    logic [XLEN-1:0]   mag1, mag2, fast_res;
    logic [XLEN:0]     mul_sum, div_shl, div_diff;
    logic [2*XLEN-1:0] mul_nxt, div_nxt, iter_nxt, mul_signed;
    logic [XLEN-1:0]   mul_res, div_pick, div_res, final_res;

    always_comb begin
        is_div   = funct3_i[2];
        s1       = (funct3_i == 3'b001) || (funct3_i == 3'b010) ||
                   (funct3_i == 3'b100) || (funct3_i == 3'b110);
        s2       = (funct3_i == 3'b001) || (funct3_i == 3'b100) || (funct3_i == 3'b110);
        neg1     = s1 && op1_i[XLEN-1];
        neg2     = s2 && op2_i[XLEN-1];
        mag1     = neg1 ? -op1_i : op1_i;
        mag2     = neg2 ? -op2_i : op2_i;
        div0     = is_div && (op2_i == '0);
        ovf      = is_div && !funct3_i[0] && (op1_i == MIN_NEG) && (op2_i == '1);
        fast_res = div0 ? (funct3_i[1] ? op1_i : '1) : (funct3_i[1] ? '0 : op1_i);
    end

    // Multiply keeps {partial_hi, multiplier}; divide keeps {remainder, dividend/quotient}.
    always_comb begin
        mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opb_q} : '0);
        mul_nxt  = {mul_sum, acc_q[XLEN-1:1]};
        div_shl  = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
        div_diff = div_shl - {1'b0, opb_q};
        div_nxt  = div_diff[XLEN] ? {div_shl[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                                  : {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
        iter_nxt = funct3_q[2] ? div_nxt : mul_nxt;

        mul_signed = neg_q ? -iter_nxt : iter_nxt;
        mul_res    = (funct3_q[1:0] == 2'b00) ? mul_signed[XLEN-1:0] : mul_signed[2*XLEN-1:XLEN];
        div_pick   = funct3_q[1] ? iter_nxt[2*XLEN-1:XLEN] : iter_nxt[XLEN-1:0];
        div_res    = neg_q ? -div_pick : div_pick;
        final_res  = funct3_q[2] ? div_res : mul_res;
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        opb_d     = opb_q;
        funct3_d  = funct3_q;
        neg_d     = neg_q;
        rd_d      = rd_q;
        rd_addr_d = '0;
        rd_data_d = '0;
        rd_wen_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i && !flush_i) begin
                    funct3_d = funct3_i;
                    rd_d     = rd_addr_i;
                    // Remainder follows the dividend; everything else follows the sign product.
                    neg_d    = (funct3_i[2] && funct3_i[1]) ? neg1 : (neg1 ^ neg2);
                    acc_d    = is_div ? {{XLEN{1'b0}}, mag1} : {{XLEN{1'b0}}, mag2};
                    opb_d    = is_div ? mag2 : mag1;
                    cnt_d    = CW'(XLEN - 1);
                    if (div0 || ovf) begin
                        state_d   = DONE;
                        rd_addr_d = rd_addr_i;
                        rd_data_d = fast_res;
                        rd_wen_d  = 1'b1;
                    end else begin
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                acc_d = iter_nxt;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    state_d   = DONE;
                    rd_addr_d = rd_q;
                    rd_data_d = final_res;
                    rd_wen_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (flush_i) begin
            state_d   = IDLE;
            rd_addr_d = '0;
            rd_data_d = '0;
            rd_wen_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            opb_q     <= '0;
            funct3_q  <= '0;
            neg_q     <= 1'b0;
            rd_q      <= '0;
            rd_addr_q <= '0;
            rd_data_q <= '0;
            rd_wen_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            opb_q     <= opb_d;
            funct3_q  <= funct3_d;
            neg_q     <= neg_d;
            rd_q      <= rd_d;
            rd_addr_q <= rd_addr_d;
            rd_data_q <= rd_data_d;
            rd_wen_q  <= rd_wen_d;
        end
    end

    // A flush landing in DONE must suppress the write-back in that same cycle.
    assign rd_wen_o  = rd_wen_q && !flush_i;
    assign busy_o    = (state_q != IDLE);
    assign rd_addr_o = rd_addr_q;
    assign rd_data_o = rd_data_q;

endmodule

// File: tb/tb_ex_muldiv.sv
// Randomised and directed bench for ex_muldiv at XLEN=32 and XLEN=8 against an arithmetic model.
module tb_ex_muldiv;

    logic        clk = 1'b0;
    logic        rst, start, flush, use8;
    logic [2:0]  f3;
    logic [63:0] a, b;
    logic [4:0]  rd;
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    logic        start32, start8, busy32, busy8, wen32, wen8;
    logic [4:0]  addr32, addr8;
    logic [31:0] data32;
    logic [7:0]  data8;
    logic        m_busy, m_wen;
    logic [4:0]  m_addr;
    logic [63:0] m_data;

    assign start32 = start && !use8;
    assign start8  = start && use8;
    assign m_busy  = use8 ? busy8 : busy32;
    assign m_wen   = use8 ? wen8 : wen32;
    assign m_addr  = use8 ? addr8 : addr32;
    assign m_data  = use8 ? {56'b0, data8} : {32'b0, data32};

    ex_muldiv #(.XLEN(32)) dut32 (
        .clk(clk), .rst(rst), .start_i(start32), .funct3_i(f3),
        .op1_i(a[31:0]), .op2_i(b[31:0]), .rd_addr_i(rd), .flush_i(flush),
        .busy_o(busy32), .rd_addr_o(addr32), .rd_data_o(data32), .rd_wen_o(wen32)
    );

    ex_muldiv #(.XLEN(8)) dut8 (
        .clk(clk), .rst(rst), .start_i(start8), .funct3_i(f3),
        .op1_i(a[7:0]), .op2_i(b[7:0]), .rd_addr_i(rd), .flush_i(flush),
        .busy_o(busy8), .rd_addr_o(addr8), .rd_data_o(data8), .rd_wen_o(wen8)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] ref_op(input int xl, input logic [2:0] f,
                                           input logic [63:0] x, input logic [63:0] y);
        logic [63:0] mask, ux, uy, mn, p, r;
        longint      sx, sy;
        mask = (64'd1 << xl) - 64'd1;
        ux   = x & mask;
        uy   = y & mask;
        mn   = 64'd1 << (xl - 1);
        sx   = longint'(signed'(ux << (64 - xl)) >>> (64 - xl));
        sy   = longint'(signed'(uy << (64 - xl)) >>> (64 - xl));
        case (f)
            3'd0:    begin p = ux * uy; r = p; end
            3'd1:    begin p = sx * sy; r = p >> xl; end
            3'd2:    begin p = sx * longint'(uy); r = p >> xl; end
            3'd3:    begin p = ux * uy; r = p >> xl; end
            3'd4:    r = (uy == 0) ? mask : (ux == mn && uy == mask) ? ux : 64'(sx / sy);
            3'd5:    r = (uy == 0) ? mask : ux / uy;
            3'd6:    r = (uy == 0) ? ux : (ux == mn && uy == mask) ? 64'd0 : 64'(sx % sy);
            default: r = (uy == 0) ? ux : ux % uy;
        endcase
        return r & mask;
    endfunction

    // Called at a negedge; drives one request and follows it to write-back.
    task automatic do_op(input logic [2:0] fx, input logic [63:0] ax, input logic [63:0] bx,
                         input logic [4:0] rdx, input bit intrude);
        int          xl, n, lat;
        logic [63:0] exp, mask;
        bit          bad_busy, bad_quiet;
        xl        = use8 ? 8 : 32;
        mask      = (64'd1 << xl) - 64'd1;
        exp       = ref_op(xl, fx, ax, bx);
        lat       = (fx[2] && (((bx & mask) == 0) || (!fx[0] && (ax & mask) == (64'd1 << (xl - 1))
                     && (bx & mask) == mask))) ? 1 : xl + 1;
        bad_busy  = 0;
        bad_quiet = 0;
        f3 = fx; a = ax; b = bx; rd = rdx; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        n = 0;
        while (n < 200) begin
            @(negedge clk);
            n++;
            if (m_wen) break;
            if (!m_busy) bad_busy = 1;
            if (m_data != 0 || m_addr != 0) bad_quiet = 1;
            if (intrude && n == 5) begin
                start = 1'b1; f3 = 3'd0; a = 64'd3; b = 64'd3; rd = ~rdx;
            end
            if (intrude && n == 6) start = 1'b0;
        end
        chk("latency", 64'(n), 64'(lat));
        chk("data", m_data, exp);
        chk("addr", 64'(m_addr), 64'(rdx));
        chk("busy_done", 64'(m_busy), 64'd1);
        chk("busy_calc", 64'(bad_busy), 64'd0);
        chk("quiet_calc", 64'(bad_quiet), 64'd0);
        @(negedge clk);
        chk("wen_pulse", 64'(m_wen), 64'd0);
        chk("idle_after", 64'(m_busy), 64'd0);
        chk("out_clear", m_data, 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        bit saw_wen;
        int sel;
        rst = 1'b1; start = 1'b0; flush = 1'b0; use8 = 1'b0;
        f3 = '0; a = '0; b = '0; rd = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy32", 64'(busy32), 64'd0);
        chk("rst_wen32", 64'(wen32), 64'd0);
        chk("rst_data32", 64'(data32), 64'd0);
        chk("rst_addr32", 64'(addr32), 64'd0);
        chk("rst_busy8", 64'(busy8), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        do_op(3'd0, 64'd7, 64'hFFFF_FFFD, 5'd7, 1'b1);
        do_op(3'd1, 64'h8000_0000, 64'hFFFF_FFFF, 5'd1, 1'b0);
        do_op(3'd2, 64'h8000_0000, 64'hFFFF_FFFF, 5'd2, 1'b0);
        do_op(3'd3, 64'h8000_0000, 64'hFFFF_FFFF, 5'd0, 1'b0);
        do_op(3'd4, 64'hFFFF_FFF9, 64'd2, 5'd4, 1'b0);
        do_op(3'd6, 64'hFFFF_FFF9, 64'd2, 5'd6, 1'b0);
        do_op(3'd5, 64'hFFFF_FFF9, 64'd2, 5'd5, 1'b0);
        do_op(3'd7, 64'hFFFF_FFF9, 64'd2, 5'd31, 1'b0);
        do_op(3'd5, 64'd5, 64'd0, 5'd8, 1'b0);
        do_op(3'd6, 64'd5, 64'd0, 5'd9, 1'b0);
        do_op(3'd4, 64'h8000_0000, 64'hFFFF_FFFF, 5'd10, 1'b0);

        // Flush at cycle 10 of a DIV, with an ignored start in between.
        f3 = 3'd4; a = 64'h1234_5678; b = 64'd100; rd = 5'd12; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        saw_wen = 0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (m_wen) saw_wen = 1;
            if (k == 5) begin start = 1'b1; f3 = 3'd0; rd = 5'd13; end
            if (k == 6) start = 1'b0;
        end
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_idle", 64'(m_busy), 64'd0);
        chk("flush_no_wen", 64'(saw_wen || m_wen), 64'd0);
        do_op(3'd4, 64'hFFFF_FFF9, 64'd2, 5'd14, 1'b0);

        // Flush arriving in DONE kills the write-back in that cycle.
        f3 = 3'd5; a = 64'd5; b = 64'd0; rd = 5'd15; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        chk("fp_done_wen", 64'(m_wen), 64'd1);
        flush = 1'b1;
        #1 chk("flush_done_wen", 64'(m_wen), 64'd0);
        @(negedge clk);
        flush = 1'b0;
        chk("flush_done_idle", 64'(m_busy), 64'd0);

        // Flush wins over a simultaneous start.
        f3 = 3'd0; a = 64'd9; b = 64'd9; rd = 5'd16; start = 1'b1; flush = 1'b1;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        chk("flush_prio", 64'(m_busy), 64'd0);

        // Reset in the middle of CALC discards the operation.
        f3 = 3'd3; a = 64'hDEAD_BEEF; b = 64'h1234_5678; rd = 5'd17; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_mid_busy", 64'(m_busy), 64'd0);
        chk("rst_mid_wen", 64'(m_wen), 64'd0);
        chk("rst_mid_data", m_data, 64'd0);
        chk("rst_mid_addr", 64'(m_addr), 64'd0);
        saw_wen = 0;
        repeat (40) begin
            @(negedge clk);
            if (m_wen) saw_wen = 1;
        end
        chk("rst_mid_no_wb", 64'(saw_wen), 64'd0);

        for (int i = 0; i < 30; i++) begin
            sel = $urandom_range(0, 9);
            a = {32'b0, $urandom()};
            b = {32'b0, $urandom()};
            if (sel == 0) b = 64'd0;
            if (sel == 1) begin a = 64'h8000_0000; b = 64'hFFFF_FFFF; end
            if (sel == 2) b = 64'($urandom_range(1, 15));
            do_op(3'($urandom_range(0, 7)), a, b, 5'($urandom_range(0, 31)), bit'(i % 4 == 0));
        end

        use8 = 1'b1;
        do_op(3'd0, 64'h0F, 64'h11, 5'd3, 1'b0);
        do_op(3'd4, 64'h80, 64'hFF, 5'd4, 1'b0);
        for (int i = 0; i < 20; i++) begin
            sel = $urandom_range(0, 7);
            a = 64'($urandom_range(0, 255));
            b = (sel == 0) ? 64'd0 : 64'($urandom_range(0, 255));
            do_op(3'($urandom_range(0, 7)), a, b, 5'($urandom_range(0, 31)), 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
